// File: rtl/insn_mem_pkg.sv
// Shared types for the instruction-memory responder: fault codes and the
// response record carried through the read pipeline and response queue.
package insn_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        FAULT_NONE       = 2'd0,
        FAULT_MISALIGNED = 2'd1,
        FAULT_RANGE      = 2'd2
    } fault_e;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        fault_e            fault;
    } resp_entry_t;

    // Misalignment outranks an out-of-range word index.
    function automatic fault_e decode_fault(input logic [1:0] low_bits, input logic over_range);
        if (low_bits != 2'b00) begin
            return FAULT_MISALIGNED;
        end else if (over_range) begin
            return FAULT_RANGE;
        end
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/insn_mem_sync_fifo.sv
// Synchronous FIFO with reset and flush clear; storage is not reset, only
// pointers and occupancy. Depth need not be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = store[rd_ptr];

    // Data storage: written on push, never cleared.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            store[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= next_ptr(wr_ptr);
            if (do_rd) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

    // The owner's credit scheme must never push into a full queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush) !(wr_en && full));

endmodule

// File: rtl/insn_mem.sv
// Instruction-memory responder: word store with a side load port, a fixed
// LATENCY read pipeline and an in-order response queue, with credit-based
// request flow control so the queue can never overflow.
module insn_mem
    import insn_mem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1,
    parameter int RESP_DEPTH  = LATENCY + 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [1:0]      resp_fault,
    input  logic            flush,
    input  logic            load_en,
    input  logic [XLEN-1:0] load_addr,
    input  logic [XLEN-1:0] load_data
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int EW = $bits(resp_entry_t);

    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [CW-1:0]   outstanding;
    logic            accept;
    logic            pop;
    logic            vld_p0;
    resp_entry_t     ent_p0;
    logic            push;
    resp_entry_t     push_ent;
    logic [EW-1:0]   head_bits;
    resp_entry_t     head_ent;
    logic            fifo_empty;
    logic            unused_fifo_full;
    logic            unused_load_bits;

    assign unused_load_bits = &{1'b0, load_addr[1:0]};

    assign req_ready = !reset && !flush && (outstanding < CW'(RESP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign vld_p0    = accept;

    assign resp_valid = !reset && !fifo_empty;
    assign pop        = resp_valid && resp_ready;
    assign head_ent   = resp_entry_t'(head_bits);
    assign resp_data  = resp_valid ? head_ent.data : '0;
    assign resp_fault = resp_valid ? head_ent.fault : FAULT_NONE;

    // Store fill from the load port; out-of-range words are dropped.
    always_ff @(posedge clock) begin
        if (load_en && !(|load_addr[XLEN-1:AW+2])) begin
            mem[load_addr[AW+1:2]] <= load_data;
        end
    end

    // Stage 0: fault decode and asynchronous store read at accept time, so a
    // same-cycle load to the same word is seen only by later reads.
    always_comb begin
        ent_p0.fault = decode_fault(req_addr[1:0], |req_addr[XLEN-1:AW+2]);
        ent_p0.data  = '0;
        if (ent_p0.fault == FAULT_NONE) begin
            ent_p0.data = mem[req_addr[AW+1:2]];
        end
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign push     = vld_p0;
            assign push_ent = ent_p0;
        end else begin : g_pipe
            logic        vld_px [LATENCY-1];
            resp_entry_t ent_px [LATENCY-1];

            // Stages 1..LATENCY-1: valid shift chain, cleared on reset or flush.
            always_ff @(posedge clock) begin
                if (reset || flush) begin
                    for (int k = 0; k < LATENCY - 1; k++) vld_px[k] <= 1'b0;
                end else begin
                    vld_px[0] <= vld_p0;
                    for (int k = 1; k < LATENCY - 1; k++) vld_px[k] <= vld_px[k-1];
                end
            end

            // Stages 1..LATENCY-1: entry payload follows its valid bit.
            always_ff @(posedge clock) begin
                ent_px[0] <= ent_p0;
                for (int k = 1; k < LATENCY - 1; k++) ent_px[k] <= ent_px[k-1];
            end

            assign push     = vld_px[LATENCY-2];
            assign push_ent = ent_px[LATENCY-2];
        end
    endgenerate

    // Credits: every accepted request holds one until its response is popped.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(pop);
        end
    end

    sync_fifo #(
        .WIDTH(EW),
        .DEPTH(RESP_DEPTH)
    ) u_resp_q (
        .clk    (clock),
        .rst    (reset),
        .flush  (flush),
        .wr_en  (push),
        .wr_data(push_ent),
        .rd_en  (pop),
        .rd_data(head_bits),
        .empty  (fifo_empty),
        .full   (unused_fifo_full)
    );

endmodule

// File: tb/tb_insn_mem.sv
// Bench for insn_mem: directed table of fault/data vectors, hand sequences for
// back-to-back, backpressure, flush, load collision and mid-transfer reset,
// then randomized traffic checked every cycle against a queue-based model.
module tb_insn_mem;
    import insn_mem_pkg::*;

    localparam int LAT = 2;
    localparam int RD  = LAT + 1;
    localparam int DW  = 1024;

    logic        clk = 1'b0;
    logic        reset, req_valid, resp_ready, flush, load_en;
    logic [31:0] req_addr, load_addr, load_data;
    logic        req_ready, resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  resp_fault;

    insn_mem #(.XLEN(32), .DEPTH_WORDS(DW), .LATENCY(LAT), .RESP_DEPTH(RD)) dut (
        .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_fault(resp_fault), .flush(flush),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  fault;
        int          avail;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  fault;
    } vec_t;

    exp_t        q[$];
    logic [31:0] ref_mem [DW];
    logic [31:0] got_d[$];
    logic [1:0]  got_f[$];
    int          got_c[$];
    int          acc_c[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] prog [4];
    vec_t        vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] ref_fault(input logic [31:0] a);
        if (a % 4 != 0) return 2'd1;
        if (a / 4 >= DW) return 2'd2;
        return 2'd0;
    endfunction

    // One clock: check outputs against the model mid-cycle, then advance the model.
    task automatic step();
        logic exp_rdy, exp_vld, acc, pop;
        exp_t e;
        e = '{data: 32'd0, fault: 2'd0, avail: 0};
        @(negedge clk);
        exp_rdy = !reset && !flush && (q.size() < RD);
        exp_vld = !reset && (q.size() > 0) && (q[0].avail <= cyc);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("resp_valid", 32'(resp_valid), 32'(exp_vld));
        if (exp_vld) begin
            chk("resp_data", resp_data, q[0].data);
            chk("resp_fault", 32'(resp_fault), 32'(q[0].fault));
        end else if (reset) begin
            chk("reset_data", resp_data, 32'd0);
            chk("reset_fault", 32'(resp_fault), 32'd0);
        end
        acc = req_valid && exp_rdy;
        pop = exp_vld && resp_ready;
        if (pop) begin
            got_d.push_back(resp_data);
            got_f.push_back(resp_fault);
            got_c.push_back(cyc);
        end
        if (acc) begin
            e.fault = ref_fault(req_addr);
            e.data  = (e.fault == 2'd0) ? ref_mem[req_addr[11:2]] : 32'd0;
            e.avail = cyc + LAT;
            acc_c.push_back(cyc);
        end
        @(posedge clk);
        if (reset || flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        if (load_en && (load_addr / 4 < DW)) ref_mem[load_addr[11:2]] = load_data;
        cyc++;
        #1;
    endtask

    task automatic clear_logs();
        got_d.delete(); got_f.delete(); got_c.delete(); acc_c.delete();
    endtask

    // Present one request until accepted, bounded.
    task automatic issue(input logic [31:0] a);
        int n0;
        n0 = acc_c.size();
        req_valid = 1'b1;
        req_addr  = a;
        for (int i = 0; i < 12 && acc_c.size() == n0; i++) step();
        req_valid = 1'b0;
        if (acc_c.size() == n0) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input int n);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 20 && got_d.size() < n; i++) step();
        repeat (3) step();
        chk("drain_count", 32'(got_d.size()), 32'(n));
    endtask

    initial begin
        prog[0] = 32'h00000013; prog[1] = 32'h00100093;
        prog[2] = 32'h00200113; prog[3] = 32'h00300193;
        vecs[0] = '{addr: 32'h0000_0000, data: 32'h00000013, fault: 2'd0};
        vecs[1] = '{addr: 32'h0000_0006, data: 32'd0,        fault: 2'd1};
        vecs[2] = '{addr: 32'h0000_1000, data: 32'd0,        fault: 2'd2};
        vecs[3] = '{addr: 32'h0000_1005, data: 32'd0,        fault: 2'd1};
        vecs[4] = '{addr: 32'h0000_000C, data: 32'h00300193, fault: 2'd0};
        vecs[5] = '{addr: 32'hFFFF_FFFC, data: 32'd0,        fault: 2'd2};

        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; flush = 1'b0;
        load_en = 1'b0; req_addr = '0; load_addr = '0; load_data = '0;
        repeat (2) step();
        reset = 1'b0;

        // Fill the whole store so every later read has a known word.
        load_en = 1'b1;
        for (int i = 0; i < DW; i++) begin
            load_addr = 32'(i) * 4;
            load_data = (i < 4) ? prog[i] : $urandom;
            step();
        end
        load_en = 1'b0;
        step();

        // Back-to-back fetch of the first four words.
        clear_logs();
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) issue(32'(i) * 4);
        drain(4);
        if (got_d.size() == 4 && acc_c.size() == 4) begin
            chk("b2b_first_latency", 32'(got_c[0]), 32'(acc_c[0] + LAT));
            for (int i = 0; i < 4; i++) begin
                chk("b2b_data", got_d[i], prog[i]);
                chk("b2b_fault", 32'(got_f[i]), 32'd0);
                chk("b2b_cycle", 32'(got_c[i]), 32'(got_c[0] + i));
                chk("b2b_accept", 32'(acc_c[i]), 32'(acc_c[0] + i));
            end
        end

        // Table of single requests with fault/data expectations.
        for (int v = 0; v < 6; v++) begin
            clear_logs();
            issue(vecs[v].addr);
            drain(1);
            if (got_d.size() == 1) begin
                chk("vec_data", got_d[0], vecs[v].data);
                chk("vec_fault", 32'(got_f[0]), 32'(vecs[v].fault));
            end
        end

        // Backpressure: only RD requests accepted, then in-order drain.
        clear_logs();
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_addr = 32'(acc_c.size() % 4) * 4;
            step();
        end
        req_valid = 1'b0;
        chk("bp_accepted", 32'(acc_c.size()), 32'(RD));
        drain(RD);
        for (int i = 0; i < RD && i < got_d.size(); i++) chk("bp_data", got_d[i], prog[i]);

        // Flush with requests in flight and queued.
        clear_logs();
        resp_ready = 1'b0;
        issue(32'h0); issue(32'h4); issue(32'h8);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("flush_no_valid", 32'(resp_valid), 32'd0);
        clear_logs();
        issue(32'h4);
        drain(1);
        if (got_d.size() == 1) chk("flush_next_data", got_d[0], 32'h00100093);

        // Reset mid-transfer: everything dropped, full credits, store intact.
        clear_logs();
        resp_ready = 1'b0;
        issue(32'h0); issue(32'h4);
        reset = 1'b1; req_valid = 1'b1;
        step();
        reset = 1'b0; req_valid = 1'b0;
        step();
        clear_logs();
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_addr = (acc_c.size() == 0) ? 32'h0 : (acc_c.size() == 1) ? 32'h4 : 32'hC;
            step();
        end
        req_valid = 1'b0;
        chk("rst_credits", 32'(acc_c.size()), 32'(RD));
        drain(3);
        if (got_d.size() == 3) begin
            chk("rst_data0", got_d[0], 32'h00000013);
            chk("rst_data1", got_d[1], 32'h00100093);
            chk("rst_data2", got_d[2], 32'h00300193);
        end

        // Load and read of the same word in one cycle: read sees the old word.
        clear_logs();
        resp_ready = 1'b1;
        load_en = 1'b1; load_addr = 32'h8; load_data = 32'hDEADBEEF;
        issue(32'h8);
        load_en = 1'b0;
        issue(32'h8);
        drain(2);
        if (got_d.size() == 2) begin
            chk("collide_old", got_d[0], 32'h00200113);
            chk("collide_new", got_d[1], 32'hDEADBEEF);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            int r;
            reset      = ($urandom % 400) == 0;
            flush      = ($urandom % 60) == 0;
            req_valid  = ($urandom % 4) != 0;
            resp_ready = ($urandom % 3) != 0;
            r = int'($urandom % 16);
            if (r < 13)       req_addr = ($urandom % DW) * 4;
            else if (r < 15)  req_addr = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
            else              req_addr = 32'($urandom_range(DW, 1 << 20)) * 4;
            load_en   = ($urandom % 8) == 0;
            load_addr = ($urandom % (DW + 16)) * 4 + ($urandom % 4);
            load_data = $urandom;
            step();
        end
        reset = 1'b0; flush = 1'b0; load_en = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        repeat (10) step();
        chk("final_empty", 32'(resp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
